// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues sequential fetches to instruction
// memory, buffers returned {pc, instr} pairs in a small FIFO and hands them to
// decode over valid/ready. A redirect flushes queued and in-flight work.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + 1'b1;
  endfunction

  // Handshake and issue decisions; reset gates outputs without waiting for a clock edge
  always_comb begin
    out_valid = ~reset & ~redirect & (count != '0);
    pop       = out_valid & out_ready;
    push      = inflight & ~redirect;
    // Slots that stay committed after this edge: queued + in flight - leaving
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    issue     = ~reset & ~redirect & (occupancy < DEPTH_OCC);
    imem_en   = issue;
    imem_addr = fetch_pc;
    out_pc    = mem[rd_ptr][63:32];
    out_instr = mem[rd_ptr][31:0];
  end

  // PC, in-flight tracking and FIFO bookkeeping; redirect overrides everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful under count, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {inflight_pc, imem_rdata};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, directed scenarios, random stream, and a
// scoreboard that checks every delivered {pc, instr} against the expected
// fetch stream (sequential from the last reset/redirect target).
module tb_fetch_unit;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Instruction memory: data valid the cycle after a request, garbage otherwise
  always @(posedge clk) imem_rdata <= imem_en ? instr_of(imem_addr) : $urandom;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected delivery stream and expected fetch address
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  logic [31:0] exp_fetch_pc;
  int          outstanding;

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc       = {pc[31:2], 2'b00};
    exp_fetch_pc = gen_pc;
    outstanding  = 0;
    top_up();
  endtask

  // Monitor: fetch addresses, delivered entries, occupancy bound, stability, progress
  logic        hold = 1'b0;
  logic [31:0] hold_pc, hold_instr;
  int          idle = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_imem_en", imem_en, 1'b0);
      hold = 1'b0;
      idle = 0;
    end else if (redirect) begin
      chk("redirect_out_valid", out_valid, 1'b0);
      chk("redirect_imem_en", imem_en, 1'b0);
      hold = 1'b0;
      idle = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_pc", out_pc, hold_pc);
        chk("hold_instr", out_instr, hold_instr);
      end
      if (imem_en) begin
        chk("fetch_addr", imem_addr, exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        outstanding++;
      end
      if (out_valid && out_ready) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_instr", out_instr, instr_of(e));
        top_up();
        outstanding--;
      end
      chk("occupancy_bound", (outstanding <= DEPTH), 1'b1);
      hold       = out_valid && !out_ready;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      if (out_ready && !out_valid) idle++;
      else idle = 0;
      chk("progress", (idle <= 3), 1'b1);
    end
  end

  initial begin
    bit got;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b1;
    restart(RESET_PC);
    #1;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_imem_en", imem_en, 1'b0);

    // T1: release with out_ready high
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t1_en0", imem_en, 1'b1);
    chk("t1_addr0", imem_addr, 32'h3000);
    @(negedge clk);
    chk("t1_addr1", imem_addr, 32'h3004);
    chk("t1_valid1", out_valid, 1'b0);
    @(negedge clk);
    chk("t1_addr2", imem_addr, 32'h3008);
    chk("t1_valid2", out_valid, 1'b1);
    chk("t1_pc2", out_pc, 32'h3000);
    @(negedge clk);
    chk("t1_pc3", out_pc, 32'h3004);
    repeat (6) @(posedge clk);

    // T2: out_ready low from reset, then released
    #1 reset = 1'b1;
    out_ready = 1'b0;
    restart(RESET_PC);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("t2_en_stalled", imem_en, 1'b0);
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_head", out_pc, 32'h3000);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("t2_pc0", out_pc, 32'h3000);
    @(negedge clk);
    chk("t2_pc1", out_pc, 32'h3004);
    @(negedge clk);
    chk("t2_pc2", out_pc, 32'h3008);

    // T3: full FIFO plus in-flight, then redirect
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 redirect = 1'b1;
    redirect_pc = 32'h0000_3100;
    restart(redirect_pc);
    #1;
    chk("t3_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 redirect = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_en", imem_en, 1'b1);
    chk("t3_addr", imem_addr, 32'h3100);
    repeat (6) @(posedge clk);

    // T4: redirect while an entry would be accepted
    #1 redirect = 1'b1;
    redirect_pc = 32'h0000_3100;
    restart(redirect_pc);
    #1;
    chk("t4_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 redirect = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        chk("t4_first_pc", out_pc, 32'h3100);
      end
    end
    chk("t4_valid_seen", got, 1'b1);
    repeat (4) @(posedge clk);

    // T5: misaligned target near the top of the address space
    #1 redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    restart(redirect_pc);
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    chk("t5_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t5_addr1", imem_addr, 32'h0000_0000);
    repeat (6) @(posedge clk);

    // T6: asynchronous reset between edges
    #3 reset = 1'b1;
    restart(RESET_PC);
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_en", imem_en, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_en_after", imem_en, 1'b1);
    chk("t6_addr_after", imem_addr, 32'h3000);

    // Random stream: back-pressure bursts and redirects
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 redirect = 1'b0;
      out_ready = c[7] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                   : $urandom;
        restart(redirect_pc);
      end
    end
    @(posedge clk);
    #1 redirect = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
